// File: rtl/rr_gnt_arbiter.sv
// rr_gnt_arbiter: registered round-robin arbiter with a bounded grant tenure.
// The grant search scans circularly upward from rr_ptr. An owner may keep the
// grant for at most HOLD_MAX consecutive cycles while others are waiting.
// If it is the only requester, its tenure restarts and it keeps the grant.
// Optional build macro RR_GNT_STATS_EN adds per-requester grant-event counters
// (gnt_cnt) and a synchronous counter clear (stats_clr).
module rr_gnt_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 8,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
`ifdef RR_GNT_STATS_EN
    input  logic                  stats_clr,
    output logic [NUM_REQ*16-1:0] gnt_cnt,
`endif
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  gnt_vld,
    output logic [ID_W-1:0]       gnt_id,
    output logic [7:0]            tenure
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Last tenure value before the owner must yield to a waiting requester.
    localparam logic [7:0] TEN_LAST = 8'(HOLD_MAX - 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]          tenure_q, tenure_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;

    logic                grant_evt;
    logic [NUM_REQ-1:0]  win_mask;
    logic [ID_W-1:0]     winner;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic [NUM_REQ-1:0]  others;
    logic                own_req;

    // First set bit of mask, scanning ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1.
    // Only called with a non-zero mask.
    function automatic logic [ID_W-1:0] pick_winner(
        input logic [NUM_REQ-1:0] mask,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W-1:0] win;
        logic            found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i >= int'(ptr)) && |(mask & (NUM_REQ'(1) << i))) begin
                win   = ID_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && (i < int'(ptr)) && |(mask & (NUM_REQ'(1) << i))) begin
                win   = ID_W'(i);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign owner_onehot = NUM_REQ'(1) << owner_q;
    assign own_req      = |(req & owner_onehot);
    assign others       = req & ~owner_onehot;

    // Next-state decision: hold, hand over, restart tenure, or go idle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        tenure_d  = tenure_q;
        grant_evt = 1'b0;
        win_mask  = '0;
        winner    = '0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_evt = 1'b1;
                    win_mask  = req;
                end
            end
            GRANT: begin
                if (own_req && (tenure_q < TEN_LAST)) begin
                    tenure_d = tenure_q + 8'd1;
                end else if (own_req) begin
                    // Tenure expired: yield only if someone else is waiting.
                    if (|others) begin
                        grant_evt = 1'b1;
                        win_mask  = others;
                    end else begin
                        tenure_d = '0;
                    end
                end else if (|req) begin
                    // Owner dropped; its bit is clear, so req is the mask.
                    grant_evt = 1'b1;
                    win_mask  = req;
                end else begin
                    state_d  = IDLE;
                    owner_d  = '0;
                    tenure_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_evt) begin
            winner   = pick_winner(win_mask, rr_ptr_q);
            state_d  = GRANT;
            owner_d  = winner;
            tenure_d = '0;
            rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
        end

        gnt_d = (state_d == GRANT) ? (NUM_REQ'(1) << owner_d) : '0;
    end

    // Arbiter state registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            tenure_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            tenure_q <= tenure_d;
            gnt_q    <= gnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = |gnt_q;
    assign gnt_id  = owner_q;
    assign tenure  = tenure_q;

`ifdef RR_GNT_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // Per-requester grant-event counters, saturating; clear wins over count
    // except that a same-cycle grant leaves the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) begin
                    cnt_q[i] <= (grant_evt && (winner == ID_W'(i))) ? 16'd1 : 16'd0;
                end else if (grant_evt && (winner == ID_W'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus, requester 0 in the low bits.
    always_comb begin
        gnt_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_cnt[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_rr_gnt_arbiter.sv
// Bench for rr_gnt_arbiter with NUM_REQ=4, HOLD_MAX=4: directed vector table,
// hand-written owner-drop and async-reset sequences, then random traffic
// checked against a behavioural model. Honours RR_GNT_STATS_EN if defined.
module tb_rr_gnt_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gnt_vld;
    logic [1:0]   gnt_id;
    logic [7:0]   tenure;
`ifdef RR_GNT_STATS_EN
    logic          clr_bit;
    logic [N*16-1:0] gnt_cnt;
    int            m_cnt [N];
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner index (-1 when idle), scan start, tenure.
    int m_owner;
    int m_ptr;
    int m_ten;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic [7:0] ten;
    } vec_t;

    vec_t vecs [30];

    rr_gnt_arbiter #(.NUM_REQ(N), .HOLD_MAX(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
`ifdef RR_GNT_STATS_EN
        .stats_clr(clr_bit),
        .gnt_cnt  (gnt_cnt),
`endif
        .gnt      (gnt),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id),
        .tenure   (tenure)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit has_bit(input logic [3:0] m, input int idx);
        return ((m >> idx) & 4'b0001) != 4'b0000;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_ten   = 0;
`ifdef RR_GNT_STATS_EN
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    endtask

    task automatic model_grant(input logic [3:0] m);
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && has_bit(m, (m_ptr + k) % N)) w = (m_ptr + k) % N;
        end
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_ten   = 0;
`ifdef RR_GNT_STATS_EN
        if (m_cnt[w] < 65535) m_cnt[w]++;
`endif
    endtask

    // One posedge worth of arbitration rules applied to the model.
    task automatic model_step(input logic [3:0] r, input bit clr);
`ifdef RR_GNT_STATS_EN
        if (clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
        if (m_owner < 0) begin
            if (r != 0) model_grant(r);
        end else if (has_bit(r, m_owner) && m_ten < HOLD - 1) begin
            m_ten++;
        end else if (has_bit(r, m_owner)) begin
            if ((r & ~4'(1 << m_owner)) != 0) model_grant(r & ~4'(1 << m_owner));
            else m_ten = 0;
        end else if (r != 0) begin
            model_grant(r);
        end else begin
            m_owner = -1;
            m_ten   = 0;
        end
    endtask

    // Apply req at a negedge, advance one posedge, return at the next negedge.
    task automatic step(input logic [3:0] r, input bit clr);
        req = r;
`ifdef RR_GNT_STATS_EN
        clr_bit = clr;
`endif
        @(posedge clk);
        model_step(r, clr);
        @(negedge clk);
`ifdef RR_GNT_STATS_EN
        clr_bit = 1'b0;
`endif
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
        check({tag, "_id"}, 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check({tag, "_ten"}, 32'(tenure), 32'(m_ten));
        check({tag, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
`ifdef RR_GNT_STATS_EN
        for (int i = 0; i < N; i++) check({tag, "_cnt"}, 32'(gnt_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
    endtask

    initial begin
        // Round-robin with all requesting, then a lone requester on bit 3.
        for (int k = 0; k < 20; k++) begin
            vecs[k].req = 4'b1111;
            vecs[k].gnt = 4'(1 << ((k / 4) % 4));
            vecs[k].id  = 2'((k / 4) % 4);
            vecs[k].ten = 8'(k % 4);
        end
        for (int k = 20; k < 30; k++) begin
            vecs[k].req = 4'b1000;
            vecs[k].gnt = 4'b1000;
            vecs[k].id  = 2'd3;
            vecs[k].ten = 8'((k - 20) % 4);
        end

        rst_n = 1'b0;
        req   = 4'b1111;
`ifdef RR_GNT_STATS_EN
        clr_bit = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_vld", 32'(gnt_vld), 32'd0);
        check("rst_id", 32'(gnt_id), 32'd0);
        check("rst_ten", 32'(tenure), 32'd0);

        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step(vecs[k].req, 1'b0);
            check("tbl_gnt", 32'(gnt), 32'(vecs[k].gnt));
            check("tbl_vld", 32'(gnt_vld), 32'd1);
            check("tbl_id", 32'(gnt_id), 32'(vecs[k].id));
            check("tbl_ten", 32'(tenure), 32'(vecs[k].ten));
`ifdef RR_GNT_STATS_EN
            if (k == 15) begin
                for (int i = 0; i < N; i++) check("rr_cnt", 32'(gnt_cnt[i*16 +: 16]), 32'd1);
            end
`endif
        end

        // Owner drop: owner 3 leaves, 0 wins, then 0 leaves for 2, then idle.
        step(4'b0101, 1'b0);
        check("drop_gnt0", 32'(gnt), 32'b0001);
        step(4'b0100, 1'b0);
        check("drop_gnt2", 32'(gnt), 32'b0100);
        check("drop_id2", 32'(gnt_id), 32'd2);
        step(4'b0000, 1'b0);
        check("idle_gnt", 32'(gnt), 32'd0);
        check("idle_vld", 32'(gnt_vld), 32'd0);
        check("idle_id", 32'(gnt_id), 32'd0);

        // Async reset mid-grant: owner 2 at tenure 2, reset between edges.
        repeat (3) step(4'b0100, 1'b0);
        check("pre_rst_gnt", 32'(gnt), 32'b0100);
        check("pre_rst_ten", 32'(tenure), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_vld", 32'(gnt_vld), 32'd0);
        check("async_ten", 32'(tenure), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 1'b0);
        check("post_rst_gnt", 32'(gnt), 32'b0010);
        check_model("post_rst");

`ifdef RR_GNT_STATS_EN
        step(4'b0110, 1'b1);
        check_model("clr");
        step(4'b0000, 1'b1);
        for (int i = 0; i < N; i++) check("clr_zero", 32'(gnt_cnt[i*16 +: 16]), 32'd0);
`endif

        // Random traffic with sticky requests and occasional async reset.
        begin
            logic [3:0] r;
            bit         c;
            r = 4'b0000;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                c = ($urandom_range(0, 19) == 0);
                step(r, c);
                check_model("rnd");
                if ($urandom_range(0, 99) == 0) begin
                    #2 rst_n = 1'b0;
                    #1;
                    model_reset();
                    check_model("rnd_rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_gnt_arbiter.md
Name: rr_gnt_arbiter

Overview:
- Parametrised successor to the free-running random grant model: a registered round-robin arbiter.
- Drives an N-bit one-hot grant bus, replacing random gnt stimulus with protocol-correct grants.
- Adds a bounded grant tenure (hold limit) so no requester is starved.
- Sits between N requesters and a shared resource. Testbench clocking blocks sample gnt at posedge clk with any input skew.

Parameters:
- NUM_REQ, 4, number of requesters; width of req/gnt; legal range 2..16
- HOLD_MAX, 8, max consecutive cycles one requester may hold gnt while others are pending; legal range 1..255
- ID_W, $clog2(NUM_REQ), width of gnt_id

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  request vector; bit i = requester i
- gnt  output  NUM_REQ  registered one-hot grant, or all-zero
- gnt_vld  output  1  high when gnt is non-zero
- gnt_id  output  ID_W  index of the granted requester; 0 when gnt_vld=0
- tenure  output  8  cycles the current owner has held gnt, minus 1; 0 when idle

Behaviour:
- Reset (rst_n=0, asynchronous): gnt=0, gnt_vld=0, gnt_id=0, tenure=0, rr_ptr=0, state=IDLE. Takes effect immediately, mid-grant included. First arbitration is on the first posedge with rst_n=1.
- States:
  - IDLE: no owner.
  - GRANT: one owner, gnt[owner]=1.
- Winner search: first set bit in the candidate mask, scanning circularly from rr_ptr upward (rr_ptr, rr_ptr+1, ..., wrapping at NUM_REQ-1 to 0).
- On every grant: rr_ptr <= (winner+1) mod NUM_REQ, tenure <= 0.
- Latency: req sampled at edge k gives gnt at edge k (registered), visible to the bench from edge k+1 sampling. One-cycle request-to-grant.
- IDLE transitions:
  - req==0: stay IDLE.
  - req!=0: candidate mask = req; grant winner; go to GRANT.
- GRANT transitions, evaluated each posedge:
  - req[owner]=1 and tenure<HOLD_MAX-1: hold; tenure increments by 1.
  - req[owner]=1, tenure==HOLD_MAX-1, other bits of req set: candidate mask = req with owner bit cleared; grant the next winner on this edge (no idle gap).
  - req[owner]=1, tenure==HOLD_MAX-1, no other request: keep the grant; tenure <= 0 (tenure restarts); rr_ptr unchanged.
  - req[owner]=0, others pending: grant the winner from req directly (no idle gap).
  - req[owner]=0, req==0: go to IDLE; gnt=0 on this edge.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld == |gnt.
  - gnt_id encodes gnt.
  - A granted bit always had req set on the sampling edge.
- Starvation bound: a requester holding req high is granted within (NUM_REQ-1)*HOLD_MAX+1 cycles.
- Simultaneous owner drop and tenure expiry: treated as owner drop.
- tenure saturates arithmetic at 8 bits; it never wraps, because HOLD_MAX<=255.

Optional Feature:
- Macro: RR_GNT_STATS_EN.
- When defined:
  - Adds output gnt_cnt, NUM_REQ*16 bits: per-requester 16-bit count of grant events (new grants only, not hold cycles).
  - Each count saturates at 0xFFFF.
  - All counts clear on reset.
  - Adds input stats_clr (1 bit): synchronous clear of all counts. If stats_clr coincides with a grant event, the count ends at 1 for that requester.
- When undefined: no gnt_cnt or stats_clr ports, no counter logic. Arbitration behaviour is identical in both builds.

Test Plan (NUM_REQ=4, HOLD_MAX=4):
- Reset state: rst_n=0 with req=4'b1111 -> gnt=0, gnt_vld=0, gnt_id=0, tenure=0. Release rst_n -> next edge gnt=4'b0001.
- Round-robin with tenure: req=4'b1111 held -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 x4. No idle cycles. tenure counts 0,1,2,3 per owner.
- Owner drop: owner 0 granted, req=4'b0101; req drops to 4'b0100 -> next edge gnt=4'b0100, gnt_id=2. Then req=0 -> gnt=0, state IDLE.
- Lone requester: req=4'b1000 held for 10 cycles -> gnt=4'b1000 for all 10 cycles. tenure runs 0,1,2,3,0,1,2,3,0,1.
- Async reset mid-grant: owner 2 with tenure=2; rst_n pulled low between edges -> gnt=0 immediately, before the next posedge. After release with req=4'b0110 -> gnt=4'b0010 (rr_ptr reset to 0).
- Stats (RR_GNT_STATS_EN): the round-robin scenario above over 16 cycles -> gnt_cnt = 1 per requester. Assert stats_clr for 1 cycle -> all counts 0.
